// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the STDP synapse array and its trace counters.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FORWARD = 2'd1,
    ST_UPDATE  = 2'd2
  } state_t;

  // Clamp a sign-extended value to the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] x, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic [31:0] trace_inc(input logic [31:0] t, input int tw);
    logic [31:0] max_val;
    max_val = (32'd1 << tw) - 32'd1;
    return (t >= max_val) ? max_val : t + 32'd1;
  endfunction

  function automatic logic [31:0] trace_dec(input logic [31:0] t);
    return (t == 32'd0) ? 32'd0 : t - 32'd1;
  endfunction

endpackage

// File: rtl/spike_trace.sv
// Saturating spike trace: increments on a spike, decays on decay_tick, spike has priority.
module spike_trace
  import snn_pkg::*;
#(
  parameter int T_DW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic            i_spike,
  input  logic            i_decay,
  output logic [T_DW-1:0] o_trace
);

  logic [T_DW-1:0] r_trace;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_trace <= '0;
    end else if (i_en) begin
      if (i_spike) begin
        r_trace <= T_DW'(trace_inc(32'(r_trace), T_DW));
      end else if (i_decay) begin
        r_trace <= T_DW'(trace_dec(32'(r_trace)));
      end
    end
  end

  assign o_trace = r_trace;

endmodule

// File: rtl/stdp_synapse_array.sv
// N_PRE-input synapse array: saturated PSP sum, per-channel STDP sweep and host weight access.
module stdp_synapse_array
  import snn_pkg::*;
#(
  parameter int N_PRE    = 8,
  parameter int DW       = 16,
  parameter int T_DW     = 4,
  parameter int LR_SHIFT = 4,
  localparam int AW      = $clog2(N_PRE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [N_PRE-1:0]     i_pre_spike,
  input  logic                 i_post_spike,
  input  logic                 i_decay_tick,
  input  logic                 i_wr_en,
  input  logic [AW-1:0]        i_wr_addr,
  input  logic signed [DW-1:0] i_wr_data,
  input  logic                 i_rd_en,
  input  logic [AW-1:0]        i_rd_addr,
  output logic signed [DW-1:0] o_rd_data,
  output logic                 o_rd_valid,
  input  logic                 i_update_en,
  input  logic signed [DW-1:0] i_learning_rate,
  output logic signed [DW-1:0] o_psp_value,
  output logic                 o_psp_valid,
  output logic                 o_busy,
  output logic                 o_update_done
);

  localparam int SW = DW + AW;
  localparam int PW = DW + T_DW + 1;

  state_t r_state, w_state_nxt;
  logic [AW-1:0] r_idx;
  logic signed [DW-1:0] r_weight [N_PRE];
  logic signed [DW-1:0] r_psp_value;
  logic r_psp_valid;
  logic signed [DW-1:0] r_rd_data;
  logic r_rd_valid;
  logic r_done;

  logic [T_DW-1:0] w_pre_trace [N_PRE];
  logic [T_DW-1:0] w_post_trace;
  logic w_fwd, w_sweep, w_last, w_wr_ok, w_rd_ok;
  logic signed [SW-1:0] w_sum;
  logic signed [DW-1:0] w_psp_sat;
  logic signed [T_DW:0] w_diff;
  logic signed [PW-1:0] w_prod, w_delta;
  logic signed [PW:0] w_wsum;
  logic signed [DW-1:0] w_new_w;

  for (genvar g = 0; g < N_PRE; g++) begin : g_pre
    spike_trace #(.T_DW(T_DW)) u_pre_trace (
      .clk     (clk),
      .rst     (rst),
      .i_en    (i_en),
      .i_spike (i_pre_spike[g]),
      .i_decay (i_decay_tick),
      .o_trace (w_pre_trace[g])
    );
  end

  spike_trace #(.T_DW(T_DW)) u_post_trace (
    .clk     (clk),
    .rst     (rst),
    .i_en    (i_en),
    .i_spike (i_post_spike),
    .i_decay (i_decay_tick),
    .o_trace (w_post_trace)
  );

  assign w_last = (r_idx == AW'(N_PRE - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_fwd       = 1'b0;
    w_sweep     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_en) w_state_nxt = ST_FORWARD;
      end
      ST_FORWARD: begin
        w_fwd = i_en;
        if (i_en && i_update_en) w_state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        w_fwd   = i_en;
        w_sweep = i_en;
        if (i_en && w_last) w_state_nxt = ST_FORWARD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy = (r_state == ST_UPDATE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_sweep && w_last;
      if (w_sweep) r_idx <= w_last ? '0 : r_idx + AW'(1);
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_PRE; i++) begin
      if (i_pre_spike[i]) w_sum = w_sum + SW'(r_weight[i]);
    end
  end

  assign w_psp_sat = DW'(sat_dw(64'(w_sum), DW));

  // Traces are read as they stand this cycle, before this cycle's spikes land.
  assign w_diff  = $signed({1'b0, w_pre_trace[r_idx]}) - $signed({1'b0, w_post_trace});
  assign w_prod  = PW'(i_learning_rate) * PW'(w_diff);
  assign w_delta = w_prod >>> LR_SHIFT;
  assign w_wsum  = (PW+1)'(r_weight[r_idx]) + (PW+1)'(w_delta);
  assign w_new_w = DW'(sat_dw(64'(w_wsum), DW));

  assign w_wr_ok = i_wr_en && !o_busy && (32'(i_wr_addr) < N_PRE);
  assign w_rd_ok = (32'(i_rd_addr) < N_PRE);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_PRE; i++) r_weight[i] <= '0;
    end else if (w_sweep) begin
      r_weight[r_idx] <= w_new_w;
    end else if (w_wr_ok) begin
      r_weight[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_psp_value <= '0;
      r_psp_valid <= 1'b0;
    end else if (w_fwd) begin
      r_psp_value <= w_psp_sat;
      r_psp_valid <= |i_pre_spike;
    end else begin
      r_psp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en) r_rd_data <= w_rd_ok ? r_weight[i_rd_addr] : '0;
    end
  end

  assign o_psp_value   = r_psp_value;
  assign o_psp_valid   = r_psp_valid;
  assign o_rd_data     = r_rd_data;
  assign o_rd_valid    = r_rd_valid;
  assign o_update_done = r_done;

endmodule

// File: tb/tb_stdp_synapse_array.sv
// Directed plus randomized bench for stdp_synapse_array against a cycle-level behavioural model.
module tb_stdp_synapse_array;
  localparam int N = 8;
  localparam int DW = 16;
  localparam int LRS = 4;
  localparam int TMAX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, post_spike, decay_tick, wr_en, rd_en, update_en;
  logic [N-1:0] pre_spike;
  logic [2:0] wr_addr, rd_addr;
  logic signed [DW-1:0] wr_data, learning_rate;
  logic signed [DW-1:0] rd_data, psp_value;
  logic rd_valid, psp_valid, busy, update_done;

  stdp_synapse_array #(.N_PRE(N), .DW(DW), .T_DW(4), .LR_SHIFT(LRS)) dut (
    .clk(clk), .rst(rst), .i_en(en), .i_pre_spike(pre_spike), .i_post_spike(post_spike),
    .i_decay_tick(decay_tick), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .i_update_en(update_en), .i_learning_rate(learning_rate), .o_psp_value(psp_value),
    .o_psp_valid(psp_valid), .o_busy(busy), .o_update_done(update_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: weights and traces as plain integers, sweep as a countdown of channels left.
  int m_w[N];
  int m_pre[N];
  int m_post;
  bit m_active;
  int m_left;
  int e_psp;
  bit e_pv, e_rv, e_done;
  int e_rd;

  function automatic int sat16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  task automatic model_step();
    bit was_busy;
    longint sum, delta;
    int idx;
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_w[i] = 0; m_pre[i] = 0; end
      m_post = 0; m_active = 0; m_left = 0;
      e_psp = 0; e_pv = 0; e_rv = 0; e_rd = 0; e_done = 0;
      return;
    end
    was_busy = (m_left > 0);
    e_rv = rd_en;
    if (rd_en) e_rd = (int'(rd_addr) < N) ? m_w[rd_addr] : 0;
    e_done = 0;
    if (en) begin
      if (m_active) begin
        sum = 0;
        for (int i = 0; i < N; i++) if (pre_spike[i]) sum += m_w[i];
        e_psp = sat16(sum);
        e_pv = (pre_spike != 0);
      end else begin
        e_pv = 0;
      end
      if (m_left > 0) begin
        idx = N - m_left;
        delta = (longint'(learning_rate) * longint'(m_pre[idx] - m_post)) >>> LRS;
        m_w[idx] = sat16(longint'(m_w[idx]) + delta);
        m_left--;
        if (m_left == 0) e_done = 1;
      end else if (m_active && update_en) begin
        m_left = N;
      end
      m_active = 1;
      for (int i = 0; i < N; i++) begin
        if (pre_spike[i]) m_pre[i] = (m_pre[i] < TMAX) ? m_pre[i] + 1 : TMAX;
        else if (decay_tick) m_pre[i] = (m_pre[i] > 0) ? m_pre[i] - 1 : 0;
      end
      if (post_spike) m_post = (m_post < TMAX) ? m_post + 1 : TMAX;
      else if (decay_tick) m_post = (m_post > 0) ? m_post - 1 : 0;
    end else begin
      e_pv = 0;
    end
    if (wr_en && !was_busy && int'(wr_addr) < N) m_w[wr_addr] = int'(wr_data);
  endtask

  task automatic compare_outputs();
    check_val("psp_valid", psp_valid, e_pv);
    if (e_pv) check_val("psp_value", psp_value, e_psp);
    check_val("rd_valid", rd_valid, e_rv);
    if (e_rv) check_val("rd_data", rd_data, e_rd);
    check_val("busy", busy, m_left > 0);
    check_val("update_done", update_done, e_done);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic clear_inputs();
    pre_spike = '0; post_spike = 0; decay_tick = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    rd_en = 0; rd_addr = '0; update_en = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1; tick(); tick();
    rst = 0; en = 1; tick();
  endtask

  task automatic write_w(input int addr, input int data);
    wr_en = 1; wr_addr = 3'(addr); wr_data = DW'(data);
    tick();
    wr_en = 0;
  endtask

  task automatic read_w(input int addr, input int exp, input string tag);
    rd_en = 1; rd_addr = 3'(addr);
    tick();
    rd_en = 0;
    check_val(tag, rd_valid, 1);
    check_val(tag, rd_data, exp);
  endtask

  int busy_cnt, done_cnt;

  initial begin
    rst = 1; en = 0; learning_rate = '0;
    for (int i = 0; i < N; i++) begin m_w[i] = 0; m_pre[i] = 0; end
    m_post = 0; m_active = 0; m_left = 0;
    clear_inputs();
    tick(); tick();
    check_val("reset_psp_valid", psp_valid, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_rd_valid", rd_valid, 0);
    rst = 0; en = 1; tick();

    write_w(0, 100); write_w(1, -30); write_w(2, 5);
    pre_spike = 8'b0000_0011; tick();
    check_val("psp_sum_70", psp_value, 70);
    check_val("psp_sum_valid", psp_valid, 1);
    pre_spike = '0; tick();
    check_val("psp_idle_valid", psp_valid, 0);

    for (int i = 0; i < N; i++) write_w(i, 32767);
    pre_spike = '1; tick();
    check_val("psp_sat_pos", psp_value, 32767);
    pre_spike = '0;
    for (int i = 0; i < N; i++) write_w(i, -32768);
    pre_spike = '1; tick();
    check_val("psp_sat_neg", psp_value, -32768);
    pre_spike = '0;

    do_reset();
    pre_spike = 8'b1;
    for (int i = 0; i < 20; i++) tick();
    check_val("trace_sat", dut.w_pre_trace[0], 15);
    decay_tick = 1; tick();
    check_val("trace_spike_wins", dut.w_pre_trace[0], 15);
    pre_spike = '0;
    for (int i = 0; i < 16; i++) tick();
    check_val("trace_floor", dut.w_pre_trace[0], 0);
    tick();
    check_val("trace_floor_hold", dut.w_pre_trace[0], m_pre[0]);
    decay_tick = 0;

    do_reset();
    pre_spike = 8'b1;
    for (int i = 0; i < 8; i++) tick();
    pre_spike = '0; post_spike = 1;
    tick(); tick();
    post_spike = 0;
    learning_rate = 16'sd32;
    busy_cnt = 0; done_cnt = 0;
    update_en = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      update_en = 0; wr_en = 0;
      busy_cnt += int'(busy);
      done_cnt += int'(update_done);
      if (c == 3) begin wr_en = 1; wr_addr = 3'd5; wr_data = 16'sd77; end
    end
    check_val("sweep_busy_cycles", busy_cnt, 8);
    check_val("sweep_done_pulses", done_cnt, 1);
    read_w(0, 12, "sweep_w0");
    read_w(5, -4, "sweep_wr_dropped");

    write_w(1, 50);
    update_en = 1; tick(); update_en = 0;
    tick(); tick();
    check_val("midsweep_busy_before", busy, 1);
    rst = 1; tick(); rst = 0;
    check_val("midsweep_busy", busy, 0);
    check_val("midsweep_done", update_done, 0);
    pre_spike = 8'b1; tick();
    check_val("midsweep_idle", psp_valid, 0);
    pre_spike = '0;
    for (int i = 0; i < N; i++) read_w(i, 0, "midsweep_weight");

    write_w(2, 5);
    rd_en = 1; rd_addr = 3'd2; wr_en = 1; wr_addr = 3'd2; wr_data = 16'sd9;
    tick();
    rd_en = 0; wr_en = 0;
    check_val("rw_same_old", rd_data, 5);
    read_w(2, 9, "rw_next_new");

    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 9) != 0);
      pre_spike = N'($urandom);
      post_spike = ($urandom_range(0, 3) == 0);
      decay_tick = ($urandom_range(0, 2) == 0);
      wr_en = ($urandom_range(0, 4) == 0);
      wr_addr = 3'($urandom);
      wr_data = DW'($urandom);
      rd_en = $urandom_range(0, 1) == 1;
      rd_addr = 3'($urandom);
      update_en = ($urandom_range(0, 19) == 0);
      learning_rate = DW'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
